// File: rtl/dwrr_credit_allocator.sv
// rtl/dwrr_credit_allocator.sv - DWRR deficit-credit replenish, lookup and consume engine
// Each tlast triggers one order-table read; the returned flow gets QUANTUM credits.

module dwrr_credit_allocator #(
  parameter int FLOW_W       = 3,
  parameter int MAX_CREDIT_W = 3,
  parameter int QUANTUM      = 2,
  parameter int ORDER_LAT    = 2,
  parameter int PEND_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    order_init_done,
  output logic                    order_rd_req,
  input  logic [FLOW_W-1:0]       order_rd_data,
  input  logic                    packet_tlast,
  input  logic [FLOW_W-1:0]       flow_check,
  output logic [MAX_CREDIT_W-1:0] flow_credit_value,
  input  logic                    consume_credit_valid,
  input  logic [FLOW_W-1:0]       consume_credit_flow,
  output logic                    busy,
  output logic                    credit_sat_err,
  output logic                    credit_undf_err,
  output logic                    pend_ovf_err
);

  localparam int NUM_FLOWS = 1 << FLOW_W;
  localparam int SUM_W     = MAX_CREDIT_W + 1;
  localparam int WAIT_W    = (ORDER_LAT > 1) ? $clog2(ORDER_LAT) : 1;

  localparam logic [SUM_W-1:0]        MAX_SUM    = SUM_W'((1 << MAX_CREDIT_W) - 1);
  localparam logic [SUM_W-1:0]        Q_SUM      = SUM_W'(QUANTUM);
  localparam logic [MAX_CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [WAIT_W-1:0]       WAIT_LOAD  = WAIT_W'(ORDER_LAT - 1);
  localparam logic [PEND_W-1:0]       PEND_MAX   = '1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_UPDATE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [WAIT_W-1:0]       wait_cnt_nxt;
  logic [PEND_W-1:0]       pending;
  logic [PEND_W-1:0]       pending_nxt;
  logic                    issue;
  logic                    pend_drop;
  logic [MAX_CREDIT_W-1:0] credit     [NUM_FLOWS];
  logic [MAX_CREDIT_W-1:0] credit_nxt [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]    sat_hit;
  logic [NUM_FLOWS-1:0]    undf_hit;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    issue        = 1'b0;
    case (state)
      S_INIT: begin
        if (order_init_done) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if ((pending != '0) || packet_tlast) begin
          issue        = 1'b1;
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = S_UPDATE;
        else                wait_cnt_nxt = wait_cnt - 1'b1;
      end
      S_UPDATE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // A tlast coinciding with an issue is netted out rather than counted then removed.
  always_comb begin
    pending_nxt = pending;
    pend_drop   = 1'b0;
    if (issue) begin
      if (!packet_tlast) pending_nxt = pending - 1'b1;
    end else if (packet_tlast) begin
      if (pending == PEND_MAX) pend_drop = 1'b1;
      else                     pending_nxt = pending + 1'b1;
    end
  end

  // Add is applied before consume so a same-cycle add makes a zero counter consumable.
  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_flow
    logic             add_hit;
    logic             sub_hit;
    logic [SUM_W-1:0] tot;
    logic [SUM_W-1:0] net;

    assign add_hit       = (state == S_UPDATE) && (order_rd_data == FLOW_W'(g));
    assign sub_hit       = consume_credit_valid && (consume_credit_flow == FLOW_W'(g));
    assign tot           = {1'b0, credit[g]} + (add_hit ? Q_SUM : '0);
    assign undf_hit[g]   = sub_hit && (tot == '0);
    assign net           = tot - ((sub_hit && (tot != '0)) ? SUM_W'(1) : '0);
    assign sat_hit[g]    = net > MAX_SUM;
    assign credit_nxt[g] = sat_hit[g] ? CREDIT_MAX : net[MAX_CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_INIT;
      wait_cnt          <= '0;
      pending           <= '0;
      order_rd_req      <= 1'b0;
      flow_credit_value <= '0;
      busy              <= 1'b0;
      credit_sat_err    <= 1'b0;
      credit_undf_err   <= 1'b0;
      pend_ovf_err      <= 1'b0;
      for (int i = 0; i < NUM_FLOWS; i++) credit[i] <= '0;
    end else begin
      state             <= state_nxt;
      wait_cnt          <= wait_cnt_nxt;
      pending           <= pending_nxt;
      order_rd_req      <= issue;
      flow_credit_value <= credit[flow_check];
      busy              <= (state_nxt != S_IDLE) || (pending_nxt != '0);
      credit_sat_err    <= |sat_hit;
      credit_undf_err   <= |undf_hit;
      pend_ovf_err      <= pend_drop;
      for (int i = 0; i < NUM_FLOWS; i++) credit[i] <= credit_nxt[i];
    end
  end

endmodule

// File: tb/tb_dwrr_credit_allocator.sv
// tb/tb_dwrr_credit_allocator.sv - bench for dwrr_credit_allocator
// Reference model tracks credits, pending tlasts and the one outstanding table read by timestamp.

module tb_dwrr_credit_allocator;

  localparam int FLOW_W = 3, MAX_CREDIT_W = 3, QUANTUM = 2, ORDER_LAT = 2, PEND_W = 4;
  localparam int NF = 8, MAXC = 7, PMAX = 15;

  typedef struct packed {
    logic       r;
    logic       idn;
    logic       tl;
    logic       cv;
    logic [2:0] cf;
    logic [2:0] fc;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       order_init_done = 1'b0;
  logic       order_rd_req;
  logic [2:0] order_rd_data = '0;
  logic       packet_tlast = 1'b0;
  logic [2:0] flow_check = '0;
  logic [2:0] flow_credit_value;
  logic       consume_credit_valid = 1'b0;
  logic [2:0] consume_credit_flow = '0;
  logic       busy;
  logic       credit_sat_err;
  logic       credit_undf_err;
  logic       pend_ovf_err;

  always #5 clk = ~clk;

  dwrr_credit_allocator #(
    .FLOW_W(FLOW_W), .MAX_CREDIT_W(MAX_CREDIT_W), .QUANTUM(QUANTUM),
    .ORDER_LAT(ORDER_LAT), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst(rst), .order_init_done(order_init_done),
    .order_rd_req(order_rd_req), .order_rd_data(order_rd_data),
    .packet_tlast(packet_tlast), .flow_check(flow_check),
    .flow_credit_value(flow_credit_value),
    .consume_credit_valid(consume_credit_valid), .consume_credit_flow(consume_credit_flow),
    .busy(busy), .credit_sat_err(credit_sat_err), .credit_undf_err(credit_undf_err),
    .pend_ovf_err(pend_ovf_err)
  );

  wire [7:0] dut_outs = {order_rd_req, busy, credit_sat_err, credit_undf_err, pend_ovf_err, flow_credit_value};
  logic [7:0] exp_outs;

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  m_cred [NF];
  int  m_pend;
  bit  m_initd;
  bit  m_inflight;
  int  m_upd_at;
  int  m_upd_id;
  int  table_q[$];
  bit  hold_en = 0;
  logic [2:0] hold_val = '0;

  function automatic stim_t mk(input logic r, input logic idn, input logic tl, input logic cv,
                               input logic [2:0] cf, input logic [2:0] fc);
    stim_t s;
    s.r = r; s.idn = idn; s.tl = tl; s.cv = cv; s.cf = cf; s.fc = fc;
    return s;
  endfunction

  // Drive one cycle of stimulus, advance the reference model over the edge, settle.
  task automatic step(input stim_t s);
    int  tot;
    bit  upd, idle;
    logic e_req, e_busy, e_sat, e_undf, e_ovf;
    logic [2:0] e_fcv;
    @(negedge clk);
    rst = s.r; order_init_done = s.idn; packet_tlast = s.tl;
    consume_credit_valid = s.cv; consume_credit_flow = s.cf; flow_check = s.fc;
    if (!s.r && m_inflight && m_upd_at == cyc) order_rd_data = 3'(m_upd_id);
    else if (hold_en) order_rd_data = hold_val;
    else order_rd_data = 3'($urandom);
    @(posedge clk);
    if (s.r) begin
      for (int f = 0; f < NF; f++) m_cred[f] = 0;
      m_pend = 0; m_initd = 0; m_inflight = 0;
      exp_outs = '0;
    end else begin
      e_fcv = 3'(m_cred[s.fc]);
      e_sat = 0; e_undf = 0; e_ovf = 0;
      upd = m_inflight && (m_upd_at == cyc);
      for (int f = 0; f < NF; f++) begin
        tot = m_cred[f] + ((upd && m_upd_id == f) ? QUANTUM : 0);
        if (s.cv && s.cf == f) begin
          if (tot == 0) e_undf = 1;
          else tot = tot - 1;
        end
        if (tot > MAXC) begin e_sat = 1; tot = MAXC; end
        m_cred[f] = tot;
      end
      idle  = m_initd && !m_inflight;
      e_req = idle && (m_pend > 0 || s.tl);
      if (e_req) begin
        m_inflight = 1;
        m_upd_at   = cyc + ORDER_LAT + 1;
        m_upd_id   = (table_q.size() > 0) ? table_q.pop_front() : int'($urandom_range(0, 7));
        if (!s.tl) m_pend--;
      end else if (s.tl) begin
        if (m_pend == PMAX) e_ovf = 1;
        else m_pend++;
      end
      if (upd) m_inflight = 0;
      if (!m_initd && s.idn) m_initd = 1;
      e_busy   = !(m_initd && !m_inflight) || (m_pend != 0);
      exp_outs = {e_req, e_busy, e_sat, e_undf, e_ovf, e_fcv};
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    int pre = 0, post = 0;
    table_q.delete(); table_q.push_back(6); hold_en = 0;
    repeat (3) s.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) s.push_back(mk(0, 0, 1'(i == 5), 0, 0, 6));
    repeat (9) s.push_back(mk(0, 1, 0, 0, 0, 6));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL reset_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (dut_outs !== 8'h00) $display("FAIL reset_outputs got=%b exp=00000000", dut_outs);
        else n_pass++;
      end
      if (i >= 3 && i < 13) pre += int'(order_rd_req);
      if (i >= 13) post += int'(order_rd_req);
    end
    n_checks++;
    if (pre !== 0) $display("FAIL init_no_req got=%0d exp=0", pre); else n_pass++;
    n_checks++;
    if (post !== 1) $display("FAIL init_one_req got=%0d exp=1", post); else n_pass++;
    n_checks++;
    if (flow_credit_value !== 3'd2) $display("FAIL init_credit got=%0d exp=2", flow_credit_value); else n_pass++;
  endtask

  task automatic test_basic_replenish();
    stim_t s[$];
    table_q.delete(); table_q.push_back(3);
    repeat (2) s.push_back(mk(1, 0, 0, 0, 0, 3));
    s.push_back(mk(0, 1, 0, 0, 0, 3));
    s.push_back(mk(0, 1, 1, 0, 0, 3));
    repeat (6) s.push_back(mk(0, 1, 0, 0, 0, 3));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL basic_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (order_rd_req !== 1'b1) $display("FAIL basic_req_latency got=%b exp=1", order_rd_req); else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (flow_credit_value !== 3'd0) $display("FAIL basic_pre_update got=%0d exp=0", flow_credit_value); else n_pass++;
      end
      if (i == 7) begin
        n_checks++;
        if (flow_credit_value !== 3'd2) $display("FAIL basic_post_update got=%0d exp=2", flow_credit_value); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s[$];
    int seq[$];
    int prev = 0, sats = 0, sat_at = -1;
    table_q.delete(); repeat (4) table_q.push_back(5);
    repeat (2) s.push_back(mk(1, 0, 0, 0, 0, 5));
    s.push_back(mk(0, 1, 0, 0, 0, 5));
    repeat (4) s.push_back(mk(0, 1, 1, 0, 0, 5));
    repeat (20) s.push_back(mk(0, 1, 0, 0, 0, 5));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL sat_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (int'(flow_credit_value) != prev) begin prev = int'(flow_credit_value); seq.push_back(prev); end
      if (credit_sat_err === 1'b1) begin sats++; sat_at = seq.size(); end
    end
    n_checks++;
    if (seq.size() != 4 || seq[0] != 2 || seq[1] != 4 || seq[2] != 6 || seq[3] != 7)
      $display("FAIL sat_sequence got=%p exp=2,4,6,7", seq);
    else n_pass++;
    n_checks++;
    if (sats !== 1 || sat_at !== 3) $display("FAIL sat_pulse got count=%0d at=%0d exp count=1 at=3", sats, sat_at);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    int reqs[$];
    int last_busy = -1;
    table_q.delete(); for (int k = 0; k < 6; k++) table_q.push_back(k);
    repeat (2) s.push_back(mk(1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0));
    repeat (6) s.push_back(mk(0, 1, 1, 0, 0, 3'($urandom)));
    repeat (30) s.push_back(mk(0, 1, 0, 0, 0, 3'($urandom)));
    for (int k = 0; k < 6; k++) s.push_back(mk(0, 1, 0, 0, 0, 3'(k)));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL burst_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (order_rd_req === 1'b1) reqs.push_back(i);
      if (busy === 1'b1 && i >= 3) last_busy = i;
      if (i >= 39) begin
        n_checks++;
        if (flow_credit_value !== 3'd2) $display("FAIL burst_credit flow=%0d got=%0d exp=2", i - 39, flow_credit_value);
        else n_pass++;
      end
    end
    n_checks++;
    if (reqs.size() !== 6) $display("FAIL burst_req_count got=%0d exp=6", reqs.size());
    else begin
      n_pass++;
      for (int k = 1; k < 6; k++) begin
        n_checks++;
        if (reqs[k] - reqs[k-1] !== 4) $display("FAIL burst_spacing k=%0d got=%0d exp=4", k, reqs[k] - reqs[k-1]);
        else n_pass++;
      end
      n_checks++;
      if (last_busy - reqs[5] !== 2) $display("FAIL burst_busy_fall got=%0d exp=2", last_busy - reqs[5]);
      else n_pass++;
    end
  endtask

  task automatic test_consume();
    stim_t s[$];
    table_q.delete(); table_q.push_back(3);
    repeat (2) s.push_back(mk(1, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 1, 2, 2));
    s.push_back(mk(0, 1, 0, 0, 0, 2));
    s.push_back(mk(0, 1, 1, 0, 0, 3));
    repeat (2) s.push_back(mk(0, 1, 0, 0, 0, 3));
    s.push_back(mk(0, 1, 0, 1, 3, 3));
    repeat (2) s.push_back(mk(0, 1, 0, 0, 0, 3));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL consume_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (credit_undf_err !== 1'b1) $display("FAIL consume_undf got=%b exp=1", credit_undf_err); else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (flow_credit_value !== 3'd0) $display("FAIL consume_zero got=%0d exp=0", flow_credit_value); else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if ({credit_undf_err, credit_sat_err} !== 2'b00) $display("FAIL consume_update_err got=%b exp=00", {credit_undf_err, credit_sat_err});
        else n_pass++;
      end
      if (i == 9) begin
        n_checks++;
        if (flow_credit_value !== 3'd1) $display("FAIL consume_update_credit got=%0d exp=1", flow_credit_value); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t s[$];
    int reqs = 0;
    table_q.delete(); table_q.push_back(4);
    hold_en = 1; hold_val = 3'd4;
    repeat (2) s.push_back(mk(1, 0, 0, 0, 0, 4));
    s.push_back(mk(0, 1, 0, 0, 0, 4));
    s.push_back(mk(0, 1, 1, 0, 0, 4));
    s.push_back(mk(1, 1, 1, 0, 0, 4));
    repeat (5) s.push_back(mk(0, 0, 0, 0, 0, 4));
    repeat (5) s.push_back(mk(0, 1, 0, 0, 0, 4));
    for (int k = 0; k < 8; k++) s.push_back(mk(0, 1, 0, 0, 0, 3'(k)));
    foreach (s[i]) begin
      step(s[i]);
      n_checks++;
      if (dut_outs !== exp_outs) $display("FAIL midwait_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (dut_outs !== 8'h00) $display("FAIL midwait_outputs got=%b exp=00000000", dut_outs); else n_pass++;
      end
      if (i >= 5) reqs += int'(order_rd_req);
      if (i == 14) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midwait_busy got=%b exp=0", busy); else n_pass++;
      end
      if (i >= 15) begin
        n_checks++;
        if (flow_credit_value !== 3'd0) $display("FAIL midwait_credit flow=%0d got=%0d exp=0", i - 15, flow_credit_value);
        else n_pass++;
      end
    end
    n_checks++;
    if (reqs !== 0) $display("FAIL midwait_no_req got=%0d exp=0", reqs); else n_pass++;
    hold_en = 0;
  endtask

  task automatic test_random_traffic();
    int ovfs = 0, errs = 0;
    table_q.delete();
    repeat (2) step(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 400; i++) begin
      step(mk(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 99) < ((i < 150) ? 95 : 40)),
              1'($urandom_range(0, 9) < 3), 3'($urandom), 3'($urandom)));
      n_checks++;
      if (dut_outs !== exp_outs) begin
        errs++;
        if (errs < 10) $display("FAIL random_model i=%0d got=%b exp=%b", i, dut_outs, exp_outs);
      end else n_pass++;
      ovfs += int'(pend_ovf_err);
    end
    n_checks++;
    if (ovfs == 0) $display("FAIL random_pend_ovf got=0 exp=>0"); else n_pass++;
  endtask

  initial begin
    for (int f = 0; f < NF; f++) m_cred[f] = 0;
    m_pend = 0; m_initd = 0; m_inflight = 0; m_upd_at = 0; m_upd_id = 0;
    exp_outs = '0;
    test_reset();
    test_basic_replenish();
    test_saturation();
    test_back_to_back();
    test_consume();
    test_reset_mid_wait();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
